// File: rtl/fsm_byte_sequencer_pkg.sv
// Shared types and constants for the byte sequencer and its "101" detector.
// Also provides a population-count helper for the hit counter.
package fsm_seq_pkg;

  localparam int WORD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    S0  = 2'd0,
    S1  = 2'd1,
    S10 = 2'd2
  } det_state_t;

  function automatic logic [3:0] popcount_word(input logic [WORD_W-1:0] v);
    logic [3:0] acc;
    acc = '0;
    for (int i = 0; i < WORD_W; i++) begin
      acc = acc + 4'(v[i]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/fsm_byte_sequencer_det.sv
// Bit-serial Mealy detector for the overlapping pattern "101".
// clr wins over en; det_out is combinational on the current bit.
module seq101_detector
  import fsm_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic bit_in,
  output logic det_out
);

  det_state_t state_q;
  det_state_t state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    det_out = 1'b0;
    if (clr) begin
      state_d = S0;
    end else if (en) begin
      unique case (state_q)
        S0:  state_d = bit_in ? S1 : S0;
        S1:  state_d = bit_in ? S1 : S10;
        S10: begin
          if (bit_in) begin
            state_d = S1;
            det_out = 1'b1;
          end else begin
            state_d = S0;
          end
        end
        default: state_d = S0;
      endcase
    end
  end

endmodule

// File: rtl/fsm_byte_sequencer.sv
// Word-level wrapper that shifts each accepted byte MSB first through the
// "101" detector and returns the per-bit detector outputs as a result word.
//
//   state | meaning
//   IDLE  | ready for a word; accept latches data and (optionally) clears detector
//   SHIFT | one bit per cycle into the detector, result bit [cnt] written
//   DONE  | result presented with out_valid until the consumer takes it
module fsm_byte_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int CARRY_STATE = 0,
  parameter int WIDTH       = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_hits,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  ctrl_state_t      state_q;
  ctrl_state_t      state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             shifting;
  logic             det_en;
  logic             det_clr;
  logic             det_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    shifting  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        shifting = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept  = in_valid && in_ready;
  assign det_en  = shifting;
  assign det_clr = accept && (CARRY_STATE == 0);

  // Counter doubles as the result bit index: it names the bit being shifted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      shreg_q <= in_data;
      cnt_q   <= CNT_W'(WIDTH - 1);
    end else if (shifting) begin
      shreg_q         <= shreg_q << 1;
      result_q[cnt_q] <= det_out;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  seq101_detector u_det (
    .clk     (clk),
    .rst     (rst),
    .en      (det_en),
    .clr     (det_clr),
    .bit_in  (shreg_q[WIDTH-1]),
    .det_out (det_out)
  );

  assign out_data = result_q;
  assign out_hits = popcount_word(result_q);

endmodule

// File: doc/fsm_byte_sequencer.md
Name: fsm_byte_sequencer

Overview:
Controller that feeds 8-bit words one bit per clock, MSB first, into a bit-serial Mealy "101" overlapping sequence detector. It assembles the per-bit detector outputs into an 8-bit result word. It sits between a word-level producer and consumer and uses valid/ready handshakes on both sides. It owns the detector's enable and clear sequencing; the detector is an internal sub-module.

Parameters:
CARRY_STATE, 0, 0 = detector state cleared at start of every word; 1 = detector state carried across words
WIDTH, 8, word width; fixed at 8 for this revision, counter sized $clog2(WIDTH)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high; clears all state
in_valid  input  1  producer has a word on in_data
in_ready  output  1  block can accept a word
in_data  input  8  word to process (a)
out_valid  output  1  result word available
out_ready  input  1  consumer accepts result
out_data  output  8  result word (b); bit i = detector output when in_data bit i was shifted
out_hits  output  4  number of 1s in out_data (0..8)
busy  output  1  high in SHIFT or DONE

Behaviour:
- Interface: clk, rst only; rst asynchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_hits=0, busy=0, bit counter=0, detector state=S0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_data into a shift register, set counter=7 and go to SHIFT. If CARRY_STATE=0, clear the detector to S0 on the same edge.
- SHIFT: one bit per cycle, MSB first. The detector consumes shreg[7]; its Mealy output is written into result bit [counter]. Shift left and decrement counter. After the bit-0 cycle, go to DONE. Exactly 8 SHIFT cycles. in_ready=0.
- DONE: out_valid=1, with out_data and out_hits stable. On out_valid&out_ready, go to IDLE on the next edge. With no out_ready, hold indefinitely; in_valid is ignored.
- Latency: accept edge at cycle 0; out_valid high from cycle 9 (8 shift cycles + 1). Throughput is 1 word per 10 cycles when out_ready is held high.
- out_hits is computed combinationally from the result register, or registered on entry to DONE; either is acceptable, but it must be valid whenever out_valid=1.
- Detector (Mealy, overlapping): S0 -(1)->S1, S0 -(0)->S0; S1 -(0)->S10, S1 -(1)->S1; S10 -(1)->S1 with output 1, S10 -(0)->S0. Output is 0 on all other transitions. The detector state advances only when en=1.
- Boundaries:
  - Reset mid-SHIFT or mid-DONE aborts the word, drops the result, and returns to IDLE with the reset values.
  - in_valid held during SHIFT/DONE is not consumed; the producer must hold it until in_ready.
  - out_ready asserted while not in DONE has no effect.
  - With CARRY_STATE=1, detector state persists across idle gaps of any length.

Decomposition:
- Package fsm_seq_pkg: state enum for the controller (IDLE, SHIFT, DONE), detector state enum (S0, S1, S10), constant WORD_W=8.
- Sub-module seq101_detector: ports clk, rst, en, clr, bit_in, det_out. det_out is combinational (Mealy). The controller drives en high in SHIFT and clr on accept when CARRY_STATE=0.

Test Plan:
- Reset, then in_data=8'd8 (00001000), out_ready=1 -> out_data=8'h00, out_hits=0, out_valid first seen 9 cycles after the accept edge.
- in_data=8'd23 (00010111) -> out_data=8'h04, out_hits=1. in_data=8'd170 (10101010) -> out_data=8'h2A, out_hits=3.
- Backpressure: in_data=8'd5, out_ready=0 for 20 cycles -> out_data=8'h01 held stable, in_ready=0 throughout. Raise out_ready -> returns to IDLE next edge, and the next word is accepted.
- CARRY_STATE=1: words 8'h02 then 8'h80 -> second result 8'h80. Same stimulus with CARRY_STATE=0 -> second result 8'h00.
- Assert rst during the 4th SHIFT cycle of 8'hAA -> out_valid never rises for that word, all outputs return to reset values immediately, and the following word 8'd23 gives 8'h04.
- Back-to-back stream 8, 23, 39, 110, 74, 65, 170, 200, 122, 96, 75, 33, 34 with out_ready=1 -> every result matches a bit-serial reference model, one result per 10 cycles, no word dropped or duplicated.
